// File: rtl/viterbi_decoder_if.sv
// Serial code-bit in / decoded-bit out handshake for viterbi_decoder.
// master: drives in/in_valid, reads out/out_valid. slave: the decoder.
interface viterbi_decoder_if;
  logic in;
  logic in_valid;
  logic out;
  logic out_valid;

  modport master (
    output in,
    output in_valid,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  in_valid,
    output out,
    output out_valid
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, 4-state trellis,
// add-compare-select with register-exchange survivors.
// Ports: clock, reset (async, active-high), bus (slave: in, in_valid,
// out, out_valid). Define VDEC_METRIC_OUT_EN to add err_metric[MW-1:0].
module viterbi_decoder #(
  parameter logic [2:0] G0       = 3'b111,
  parameter logic [2:0] G1       = 3'b101,
  parameter int         TB_DEPTH = 12,
  parameter int         MW       = 5
) (
  input  logic          clock,
  input  logic          reset,
`ifdef VDEC_METRIC_OUT_EN
  output logic [MW-1:0] err_metric,
`endif
  viterbi_decoder_if.slave bus
);

  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [MW-1:0] MMAX  = '1;
  localparam logic [CW-1:0] CMAX  = CW'(TB_DEPTH);
  localparam logic [CW-1:0] CLAST = CW'(TB_DEPTH - 1);

  typedef logic [MW-1:0]       metric_t;
  typedef logic [TB_DEPTH-1:0] surv_t;

  logic          phase;
  logic          c0_q;
  metric_t       metric [4];
  surv_t         surv   [4];
  logic [CW-1:0] cnt;

  logic          acs;
  logic [1:0]    rx;
  logic [1:0]    pa  [4];
  logic [1:0]    pb  [4];
  logic [1:0]    wp  [4];
  metric_t       ca  [4];
  metric_t       cb  [4];
  metric_t       nm  [4];
  surv_t         nsv [4];
  metric_t       mn;
  logic [1:0]    best;

  // expected pair for transition bits {u,s1,s0}; c0 in bit 1
  function automatic logic [1:0] exp_pair(
    input logic [2:0] r
  );
    return {^(G0 & r), ^(G1 & r)};
  endfunction

  function automatic logic [1:0] bmet(
    input logic [1:0] rcv,
    input logic [2:0] r
  );
    logic [1:0] d;
    d = rcv ^ exp_pair(r);
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic metric_t sat_add(
    input metric_t    a,
    input logic [1:0] b
  );
    logic [MW:0] s;
    s = {1'b0, a} + {{(MW-1){1'b0}}, b};
    return s[MW] ? MMAX : s[MW-1:0];
  endfunction

  assign acs = bus.in_valid & phase;

  // next state i = {u,s1}; its predecessors are {s1,0} and {s1,1}
  always_comb begin
    rx = {c0_q, bus.in};
    for (int i = 0; i < 4; i++) begin
      pa[i] = {i[0], 1'b0};
      pb[i] = {i[0], 1'b1};
      ca[i] = sat_add(metric[pa[i]],
                      bmet(rx, {i[1], pa[i]}));
      cb[i] = sat_add(metric[pb[i]],
                      bmet(rx, {i[1], pb[i]}));
      // ties go to the lower-index predecessor
      if (cb[i] < ca[i]) begin
        wp[i] = pb[i];
        nm[i] = cb[i];
      end else begin
        wp[i] = pa[i];
        nm[i] = ca[i];
      end
      nsv[i] = {surv[wp[i]][TB_DEPTH-2:0], i[1]};
    end
  end

  always_comb begin
    mn = nm[0];
    for (int i = 1; i < 4; i++) begin
      if (nm[i] < mn) mn = nm[i];
    end
  end

  // lowest-index state holding the minimum
  always_comb begin
    best = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (nm[i] == mn) best = 2'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      c0_q  <= 1'b0;
    end else if (bus.in_valid) begin
      phase <= ~phase;
      if (!phase) c0_q <= bus.in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      metric[0] <= '0;
      for (int i = 1; i < 4; i++) begin
        metric[i] <= MMAX;
      end
      for (int i = 0; i < 4; i++) begin
        surv[i] <= '0;
      end
      cnt <= '0;
    end else if (acs) begin
      for (int i = 0; i < 4; i++) begin
        metric[i] <= nm[i] - mn;
        surv[i]   <= nsv[i];
      end
      if (cnt != CMAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (acs) begin
        bus.out       <= nsv[best][TB_DEPTH-1];
        bus.out_valid <= (cnt >= CLAST);
      end
    end
  end

`ifdef VDEC_METRIC_OUT_EN
  logic [MW:0] err_sum;

  assign err_sum = {1'b0, err_metric} + {1'b0, mn};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_metric <= '0;
    end else if (acs) begin
      err_metric <= err_sum[MW] ? MMAX : err_sum[MW-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: directed code streams,
// expected data bits queued at issue, popped on each out_valid.
module tb_viterbi_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  viterbi_decoder_if bus ();

`ifdef VDEC_METRIC_OUT_EN
  logic [4:0] err_metric;
`endif

  viterbi_decoder #(
    .TB_DEPTH(12),
    .MW(5)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef VDEC_METRIC_OUT_EN
    .err_metric(err_metric),
`endif
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit exp_q [$];
  bit drv_c1   = 1'b0;
  bit tb_phase = 1'b0;
  bit mon_e;

  // data 1,0,1,1,0,0 encoded from state 00; pair = {c0,c1}
  logic [1:0] clean_enc [6] =
    '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  bit clean_dat [6] = '{1, 0, 1, 1, 0, 0};

  task automatic check(
    input string nm,
    input int    act,
    input int    exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      check("c1_edge", int'(drv_c1), 1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid=1 expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check("out", int'(bus.out), int'(mon_e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
      drv_c1 = 1'b0;
    end
  endtask

  task automatic send_bit(input bit b, input int gap);
    @(negedge clock);
    bus.in       = b;
    bus.in_valid = 1'b1;
    drv_c1       = tb_phase;
    tb_phase     = ~tb_phase;
    idle(gap);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
    drv_c1       = 1'b0;
    tb_phase     = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++)
      @(negedge clock);
    check(nm, exp_q.size(), 0);
  endtask

  // 6 data pairs + 11 flush pairs; outputs on pairs 11..16
  task automatic send_stream(input int gap, input bit err);
    for (int p = 0; p < 17; p++) begin
      logic [1:0] pr;
      pr = (p < 6) ? clean_enc[p] : 2'b00;
      if (err && p == 2) pr = 2'b10;
      if (p >= 11) exp_q.push_back(clean_dat[p-11]);
      send_bit(pr[1], gap);
      send_bit(pr[0], gap);
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.in       = 1'b0;
    bus.in_valid = 1'b0;

    // idle after reset
    do_reset();
    check("rst_out", int'(bus.out), 0);
    check("rst_ov", int'(bus.out_valid), 0);
    repeat (20) begin
      @(negedge clock);
      check("idle_ov", int'(bus.out_valid), 0);
    end
    check("idle_out", int'(bus.out), 0);

    // clean back-to-back stream
    do_reset();
    send_stream(0, 1'b0);
    wait_drain("clean_drain");
`ifdef VDEC_METRIC_OUT_EN
    check("clean_err", int'(err_metric), 0);
`endif

    // single channel bit error in pair 3
    do_reset();
    send_stream(0, 1'b1);
    wait_drain("err_drain");
`ifdef VDEC_METRIC_OUT_EN
    check("err_metric", int'(err_metric), 1);
`endif

    // 3 idle cycles after every bit
    do_reset();
    send_stream(3, 1'b0);
    wait_drain("gap_drain");

    // stale c0 before a reset must be discarded
    do_reset();
    send_bit(1'b1, 0);
    idle(2);
    do_reset();
    send_stream(0, 1'b0);
    wait_drain("midpair_drain");

    // all-zero stream: 40 pairs -> 29 zero outputs
    do_reset();
    for (int p = 0; p < 40; p++) begin
      if (p >= 11) exp_q.push_back(1'b0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
    end
    idle(2);
    wait_drain("zero_drain");

    // async reset clears a live out_valid pulse
    do_reset();
    for (int p = 0; p < 12; p++) begin
      if (p == 11) exp_q.push_back(1'b0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
    end
    @(posedge clock);
    #2;
    check("pulse_hi", int'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check("async_clr", int'(bus.out_valid), 0);
    check("async_out", int'(bus.out), 0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    drv_c1 = 1'b0;
    wait_drain("async_drain");
    do_reset();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by vencoder.
- Consumes the encoder's serial code-bit stream and reconstructs the original data bits after a fixed decode depth.
- Sits at the receive end of the PRML channel model, opposite vencoder.
- 4-state trellis, add-compare-select (ACS), register-exchange survivor memory.

Parameters:
- G0, 3'b111, generator taps for first code bit c0; bit[2]=u (current input), bit[1]=s1 (previous input), bit[0]=s0 (input before that).
- G1, 3'b101, generator taps for second code bit c1; same bit ordering.
- TB_DEPTH, 12, survivor length in symbols and decode latency in symbols; legal range 4..32.
- MW, 5, path-metric width in bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  serial code bit; sampled only when in_valid=1.
- in_valid  input  1  qualifies in; gaps of any length allowed.
- out  output  1  decoded data bit, registered.
- out_valid  output  1  one-cycle pulse qualifying out.

Behaviour:
- Reset (async, active-high):
  - phase=0; metric[0]=0, metrics[1..3]=all-ones.
  - All survivor registers cleared; symbol counter cleared.
  - out=0, out_valid=0.
- Pairing:
  - First accepted bit after reset is c0; the next is c1.
  - The phase flag toggles on each in_valid.
  - c0 is held in a register until its c1 arrives.
- State definition: state={s1,s0}.
  - Input u moves the trellis to {u,s1}.
  - Expected bits: c0=^(G0&{u,s1,s0}), c1=^(G1&{u,s1,s0}).
- ACS runs in the clock edge that accepts c1.
  - Branch metric = Hamming distance between received pair and expected pair (0..2).
  - For each next state, the two candidate sums are compared; the smaller wins.
  - Tie: the predecessor with the lower state index wins.
  - Additions saturate at 2^MW-1.
- Normalization, same edge:
  - The minimum of the four new metrics is subtracted from all four, so the best metric is always 0.
- Survivor (register-exchange):
  - New survivor = winning predecessor's survivor shifted left by one, with u (= MSB of next state) inserted at bit 0.
- Output:
  - best = lowest-index state whose new metric is 0.
  - out = survivor[best][TB_DEPTH-1], registered on the same edge as the ACS.
  - out_valid=1 for exactly one cycle on that edge, once the symbol counter ≥ TB_DEPTH-1 (i.e. from the TB_DEPTH-th pair onward).
  - The symbol counter saturates at TB_DEPTH.
- Latency:
  - Data bit k appears on out when pair k+TB_DEPTH-1 is accepted.
  - Earlier bits are never emitted, so the first TB_DEPTH-1 data bits of a stream are not lost; they are emitted late.
  - The stream must be followed by TB_DEPTH-1 flush pairs (encoder fed zeros) to drain it.
- in_valid=0: no state change; out_valid=0.
- Reset mid-pair discards the held c0; the next accepted bit is c0.
- Pairs arriving on back-to-back cycles (bit every cycle) sustain full throughput: one decoded bit per two clocks.

Optional Feature:
- Macro: VDEC_METRIC_OUT_EN.
- Defined:
  - Adds output port err_metric [MW-1:0].
  - Holds the running sum of the un-normalized minimum metric subtracted at each ACS, saturating at 2^MW-1.
  - Gives an estimate of channel bit errors corrected since reset.
  - Reset value 0; updates on the same edge as out_valid.
- Undefined:
  - Port and logic absent; decode behaviour identical.

Test Plan:
- Reset release, no in_valid for 20 cycles -> out=0, out_valid=0 throughout; reset asserted mid-run clears out_valid within the same cycle (async).
- Clean stream, data 1,0,1,1,0,0 then 11 zeros:
  - Encoded bits sent back-to-back: 11 10 00 01 01 11 00…
  - With TB_DEPTH=12: out_valid first pulses on the 12th pair.
  - out sequence = 1,0,1,1,0,0,0…; err_metric stays 0.
- Single bit error: same stream with the 3rd pair received as 10 instead of 00 -> identical decoded sequence 1,0,1,1,0,0; err_metric=1.
- Gapped input: same clean stream with in_valid low for 3 cycles between every bit, including between c0 and c1 -> identical out sequence; out_valid pulses only on c1-accepting edges.
- Mid-pair reset: send c0=1, assert reset, then resend the clean stream -> decode identical to the clean case; the stale c0 has no effect.
- All-zero stream of 40 pairs -> 29 out_valid pulses, all out=0.
